// File: rtl/mem_access_stage_pkg.sv
// Shared RV32I pipeline types for the MEM stage: stage registers, MEM FSM states, funct3 codes.
package mem_access_stage_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_HOLD
  } mem_fsm_state_t;

  localparam logic [2:0] load_f3_lb  = 3'b000;
  localparam logic [2:0] load_f3_lh  = 3'b001;
  localparam logic [2:0] load_f3_lw  = 3'b010;
  localparam logic [2:0] load_f3_lbu = 3'b100;
  localparam logic [2:0] load_f3_lhu = 3'b101;

  localparam logic [2:0] store_f3_sb = 3'b000;
  localparam logic [2:0] store_f3_sh = 3'b001;
  localparam logic [2:0] store_f3_sw = 3'b010;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        regf_we;
    logic        load;
    logic [2:0]  memop;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] rs2_data;
    logic [31:0] aluout;
  } ex_mem_stage_reg_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] order;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic        regf_we;
    logic [31:0] rd_data;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } mem_wb_stage_reg_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory port between the MEM stage (master) and the data memory (slave).
interface mem_access_stage_if;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/mem_access_stage_load_align.sv
// Load data alignment: shift the read word to the addressed byte, then sign/zero-extend.
module load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] rd_data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {byte_off, 3'b000};
    case (funct3)
      load_f3_lb:  rd_data = {{24{shifted[7]}}, shifted[7:0]};
      load_f3_lh:  rd_data = {{16{shifted[15]}}, shifted[15:0]};
      load_f3_lbu: rd_data = {24'h0, shifted[7:0]};
      load_f3_lhu: rd_data = {16'h0, shifted[15:0]};
      default:     rd_data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: one dmem request per load/store, stalls until the response, builds MEM/WB.
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  ex_mem_stage_reg_t   ex_mem_reg,
  input  logic                stall,
  mem_access_stage_if.master  dmem,
  output mem_wb_stage_reg_t   mem_wb_reg_next,
  output logic                mem_stall
);

  mem_fsm_state_t state_q, state_d;
  logic [63:0]    last_done_order;
  logic [63:0]    issued_order;
  logic [31:0]    resp_buf;

  logic           is_memop, new_op;
  logic           issue, capture, complete;
  logic [1:0]     byte_off;
  logic [3:0]     rmask_sh, wmask_sh;
  logic [31:0]    word_addr, store_data, rdata_src, aligned;

  assign byte_off   = ex_mem_reg.mem_addr[1:0];
  assign word_addr  = {ex_mem_reg.mem_addr[31:2], 2'b00};
  assign rmask_sh   = ex_mem_reg.mem_rmask << byte_off;
  assign wmask_sh   = ex_mem_reg.mem_wmask << byte_off;
  assign store_data = ex_mem_reg.rs2_data << {byte_off, 3'b000};
  assign is_memop   = ex_mem_reg.valid && (|ex_mem_reg.mem_rmask || |ex_mem_reg.mem_wmask);
  // An op already completed but still held in EX/MEM by an external stall must not reissue.
  assign new_op     = is_memop && (ex_mem_reg.order != last_done_order);
  assign rdata_src  = (state_q == MEM_HOLD) ? resp_buf : dmem.dmem_rdata;

  load_align u_load_align (
    .rdata    (rdata_src),
    .byte_off (byte_off),
    .funct3   (ex_mem_reg.memop),
    .rd_data  (aligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= MEM_IDLE;
      last_done_order <= '1;
      issued_order    <= '0;
      resp_buf        <= '0;
    end else begin
      state_q <= state_d;
      if (issue)    issued_order    <= ex_mem_reg.order;
      if (capture)  resp_buf        <= dmem.dmem_rdata;
      if (complete) last_done_order <= issued_order;
    end
  end

  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    capture  = 1'b0;
    complete = 1'b0;
    case (state_q)
      MEM_IDLE: if (new_op) begin
        issue   = 1'b1;
        state_d = MEM_WAIT;
      end
      MEM_WAIT: if (dmem.dmem_resp) begin
        if (stall) begin
          capture = 1'b1;
          state_d = MEM_HOLD;
        end else begin
          complete = 1'b1;
          state_d  = MEM_IDLE;
        end
      end
      MEM_HOLD: if (!stall) begin
        complete = 1'b1;
        state_d  = MEM_IDLE;
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  always_comb begin
    dmem.dmem_addr  = '0;
    dmem.dmem_rmask = '0;
    dmem.dmem_wmask = '0;
    dmem.dmem_wdata = '0;
    mem_stall       = 1'b0;
    mem_wb_reg_next = '0;
    if (!rst) begin
      mem_stall = issue || ((state_q != MEM_IDLE) && !complete);
      if (issue) begin
        dmem.dmem_addr  = word_addr;
        dmem.dmem_rmask = rmask_sh;
        dmem.dmem_wmask = wmask_sh;
        dmem.dmem_wdata = store_data;
      end
      if (ex_mem_reg.valid) begin
        mem_wb_reg_next.order   = ex_mem_reg.order;
        mem_wb_reg_next.pc      = ex_mem_reg.pc;
        mem_wb_reg_next.inst    = ex_mem_reg.inst;
        mem_wb_reg_next.rd      = ex_mem_reg.rd;
        mem_wb_reg_next.regf_we = ex_mem_reg.regf_we && !(|ex_mem_reg.mem_wmask);
        mem_wb_reg_next.rd_data = ex_mem_reg.load ? aligned : ex_mem_reg.aluout;
        if (is_memop) begin
          mem_wb_reg_next.valid     = complete;
          mem_wb_reg_next.mem_addr  = word_addr;
          mem_wb_reg_next.mem_rmask = rmask_sh;
          mem_wb_reg_next.mem_wmask = wmask_sh;
          mem_wb_reg_next.mem_rdata = rdata_src;
          mem_wb_reg_next.mem_wdata = store_data;
        end else begin
          mem_wb_reg_next.valid = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage with hand-computed expectations.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              stall;
  ex_mem_stage_reg_t ex_mem_reg;
  mem_wb_stage_reg_t mem_wb_reg_next;
  logic              mem_stall;

  mem_access_stage_if dmem_bus ();

  mem_access_stage dut (
    .clk             (clk),
    .rst             (rst),
    .ex_mem_reg      (ex_mem_reg),
    .stall           (stall),
    .dmem            (dmem_bus),
    .mem_wb_reg_next (mem_wb_reg_next),
    .mem_stall       (mem_stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ex_mem_stage_reg_t mk(input logic [63:0] order, input logic load,
                                           input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [3:0] rmask, input logic [3:0] wmask,
                                           input logic [31:0] rs2, input logic [31:0] alu,
                                           input logic [4:0] rd, input logic we);
    ex_mem_stage_reg_t e;
    e           = '0;
    e.valid     = 1'b1;
    e.order     = order;
    e.pc        = 32'h0000_1000;
    e.load      = load;
    e.memop     = f3;
    e.mem_addr  = addr;
    e.mem_rmask = rmask;
    e.mem_wmask = wmask;
    e.rs2_data  = rs2;
    e.aluout    = alu;
    e.rd        = rd;
    e.regf_we   = we;
    return e;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int nstall, nreq, nvalid;

  initial begin
    rst                 = 1'b1;
    stall               = 1'b0;
    dmem_bus.dmem_resp  = 1'b0;
    dmem_bus.dmem_rdata = '0;
    ex_mem_reg = mk(64'd0, 1'b1, load_f3_lw, 32'h1000_0000, 4'b1111, 4'b0000, '0, '0, 5'd1, 1'b1);

    // Reset: outputs zero even with a valid load presented
    @(negedge clk);
    check("rst_mem_stall", 64'(mem_stall), 64'd0);
    check("rst_rmask", 64'(dmem_bus.dmem_rmask), 64'd0);
    check("rst_valid", 64'(mem_wb_reg_next.valid), 64'd0);
    next_cycle();
    rst = 1'b0;

    // lw x5, 0x1000_0008, response after three wait cycles
    ex_mem_reg = mk(64'd1, 1'b1, load_f3_lw, 32'h1000_0008, 4'b1111, 4'b0000, '0, '0, 5'd5, 1'b1);
    nstall = 0;
    nreq   = 0;
    for (int c = 0; c < 5; c++) begin
      dmem_bus.dmem_resp  = (c == 4);
      dmem_bus.dmem_rdata = (c == 4) ? 32'hDEAD_BEEF : 32'h0;
      @(negedge clk);
      if (mem_stall) nstall++;
      if (dmem_bus.dmem_rmask != 4'b0) nreq++;
      if (c == 0) begin
        check("lw_addr", 64'(dmem_bus.dmem_addr), 64'h1000_0008);
        check("lw_rmask", 64'(dmem_bus.dmem_rmask), 64'hF);
      end
      if (c == 4) begin
        check("lw_valid", 64'(mem_wb_reg_next.valid), 64'd1);
        check("lw_rd_data", 64'(mem_wb_reg_next.rd_data), 64'hDEAD_BEEF);
        check("lw_rd", 64'(mem_wb_reg_next.rd), 64'd5);
        check("lw_stall_done", 64'(mem_stall), 64'd0);
      end
      next_cycle();
    end
    check("lw_stall_cycles", 64'(nstall), 64'd4);
    check("lw_req_count", 64'(nreq), 64'd1);
    dmem_bus.dmem_resp = 1'b0;
    @(negedge clk);
    check("lw_no_reissue_rmask", 64'(dmem_bus.dmem_rmask), 64'd0);
    check("lw_no_reissue_stall", 64'(mem_stall), 64'd0);
    next_cycle();

    // lb at byte 3 of 0x80FF_FFFF: sign-extended
    ex_mem_reg = mk(64'd2, 1'b1, load_f3_lb, 32'h1000_0013, 4'b0001, 4'b0000, '0, '0, 5'd6, 1'b1);
    @(negedge clk);
    check("lb_rmask", 64'(dmem_bus.dmem_rmask), 64'h8);
    check("lb_addr", 64'(dmem_bus.dmem_addr), 64'h1000_0010);
    next_cycle();
    dmem_bus.dmem_resp  = 1'b1;
    dmem_bus.dmem_rdata = 32'h80FF_FFFF;
    @(negedge clk);
    check("lb_valid", 64'(mem_wb_reg_next.valid), 64'd1);
    check("lb_rd_data", 64'(mem_wb_reg_next.rd_data), 64'hFFFF_FF80);
    next_cycle();
    dmem_bus.dmem_resp = 1'b0;

    // Same access as lbu: zero-extended
    ex_mem_reg = mk(64'd3, 1'b1, load_f3_lbu, 32'h1000_0013, 4'b0001, 4'b0000, '0, '0, 5'd6, 1'b1);
    next_cycle();
    dmem_bus.dmem_resp  = 1'b1;
    dmem_bus.dmem_rdata = 32'h80FF_FFFF;
    @(negedge clk);
    check("lbu_rd_data", 64'(mem_wb_reg_next.rd_data), 64'h0000_0080);
    next_cycle();
    dmem_bus.dmem_resp = 1'b0;

    // sh 0x1234 to byte offset 2
    ex_mem_reg = mk(64'd4, 1'b0, store_f3_sh, 32'h1000_0022, 4'b0000, 4'b0011, 32'h0000_1234, '0, 5'd0, 1'b1);
    @(negedge clk);
    check("sh_wmask", 64'(dmem_bus.dmem_wmask), 64'hC);
    check("sh_wdata", 64'(dmem_bus.dmem_wdata), 64'h1234_0000);
    check("sh_rmask", 64'(dmem_bus.dmem_rmask), 64'd0);
    next_cycle();
    dmem_bus.dmem_resp  = 1'b1;
    dmem_bus.dmem_rdata = 32'h0;
    @(negedge clk);
    check("sh_valid", 64'(mem_wb_reg_next.valid), 64'd1);
    check("sh_regf_we", 64'(mem_wb_reg_next.regf_we), 64'd0);
    next_cycle();
    dmem_bus.dmem_resp = 1'b0;

    // lbu whose response arrives under an external stall
    ex_mem_reg = mk(64'd5, 1'b1, load_f3_lbu, 32'h1000_0040, 4'b0001, 4'b0000, '0, '0, 5'd9, 1'b1);
    next_cycle();
    stall               = 1'b1;
    dmem_bus.dmem_resp  = 1'b1;
    dmem_bus.dmem_rdata = 32'h0000_00AA;
    @(negedge clk);
    check("hold_resp_stall", 64'(mem_stall), 64'd1);
    check("hold_resp_valid", 64'(mem_wb_reg_next.valid), 64'd0);
    next_cycle();
    dmem_bus.dmem_resp  = 1'b0;
    dmem_bus.dmem_rdata = 32'h0000_0055;
    nstall = 0;
    nreq   = 0;
    nvalid = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (mem_stall) nstall++;
      if (dmem_bus.dmem_rmask != 4'b0) nreq++;
      if (mem_wb_reg_next.valid) nvalid++;
      next_cycle();
    end
    check("hold_stall_cycles", 64'(nstall), 64'd5);
    check("hold_no_request", 64'(nreq), 64'd0);
    check("hold_no_valid", 64'(nvalid), 64'd0);
    stall = 1'b0;
    @(negedge clk);
    check("hold_release_valid", 64'(mem_wb_reg_next.valid), 64'd1);
    check("hold_release_rd_data", 64'(mem_wb_reg_next.rd_data), 64'h0000_00AA);
    check("hold_release_stall", 64'(mem_stall), 64'd0);
    next_cycle();
    @(negedge clk);
    check("hold_after_valid", 64'(mem_wb_reg_next.valid), 64'd0);
    check("hold_after_rmask", 64'(dmem_bus.dmem_rmask), 64'd0);
    next_cycle();

    // add passes straight through, then lw with a one-cycle response
    ex_mem_reg = mk(64'd6, 1'b0, 3'b000, 32'h0, 4'b0000, 4'b0000, '0, 32'h0000_0033, 5'd7, 1'b1);
    @(negedge clk);
    check("add_stall", 64'(mem_stall), 64'd0);
    check("add_valid", 64'(mem_wb_reg_next.valid), 64'd1);
    check("add_rd_data", 64'(mem_wb_reg_next.rd_data), 64'h33);
    check("add_regf_we", 64'(mem_wb_reg_next.regf_we), 64'd1);
    check("add_rmask", 64'(dmem_bus.dmem_rmask), 64'd0);
    next_cycle();
    ex_mem_reg = mk(64'd7, 1'b1, load_f3_lw, 32'h2000_0004, 4'b1111, 4'b0000, '0, '0, 5'd8, 1'b1);
    nreq = 0;
    @(negedge clk);
    if (dmem_bus.dmem_rmask != 4'b0) nreq++;
    next_cycle();
    dmem_bus.dmem_resp  = 1'b1;
    dmem_bus.dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    check("b2b_lw_rd_data", 64'(mem_wb_reg_next.rd_data), 64'h1234_5678);
    next_cycle();
    dmem_bus.dmem_resp = 1'b0;
    stall = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (dmem_bus.dmem_rmask != 4'b0) nreq++;
      next_cycle();
    end
    check("b2b_req_count", 64'(nreq), 64'd1);
    stall = 1'b0;

    // Reset in the middle of WAIT, then a stray response
    ex_mem_reg = mk(64'd8, 1'b1, load_f3_lw, 32'h3000_0000, 4'b1111, 4'b0000, '0, '0, 5'd3, 1'b1);
    next_cycle();
    #2;
    rst = 1'b1;
    #1;
    check("rst_wait_stall", 64'(mem_stall), 64'd0);
    check("rst_wait_valid", 64'(mem_wb_reg_next.valid), 64'd0);
    next_cycle();
    rst                 = 1'b0;
    ex_mem_reg          = '0;
    dmem_bus.dmem_resp  = 1'b1;
    dmem_bus.dmem_rdata = 32'h0000_0BAD;
    @(negedge clk);
    check("stray_valid", 64'(mem_wb_reg_next.valid), 64'd0);
    check("stray_stall", 64'(mem_stall), 64'd0);
    check("invalid_rd_data", 64'(mem_wb_reg_next.rd_data), 64'd0);
    next_cycle();
    dmem_bus.dmem_resp = 1'b0;
    ex_mem_reg = mk(64'd8, 1'b1, load_f3_lw, 32'h3000_0000, 4'b1111, 4'b0000, '0, '0, 5'd3, 1'b1);
    @(negedge clk);
    check("post_rst_reissue", 64'(dmem_bus.dmem_rmask), 64'hF);
    next_cycle();
    dmem_bus.dmem_resp  = 1'b1;
    dmem_bus.dmem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    check("post_rst_rd_data", 64'(mem_wb_reg_next.rd_data), 64'hCAFE_F00D);
    next_cycle();
    dmem_bus.dmem_resp = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the RV32I 5-stage pipeline; consumes the EX/MEM pipeline register and acts as the initiator toward the data-memory port (dmem).
- Issues exactly one dmem request per valid load/store and holds the pipeline until dmem_resp.
- Aligns and sign/zero-extends load data, shifts store data into byte lanes, and produces the MEM/WB register contents.
- Non-memory instructions pass through combinationally with zero added latency.

Parameters:
- none (widths fixed by rv32i_types)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ex_mem_reg  in  ex_mem_stage_reg_t  registered EX/MEM contents (valid, order, pc, inst, rd, regf_we, load, memop, mem_addr, mem_rmask, mem_wmask, rs2_data, aluout)
- stall  in  1  external hold from the fetch side; MEM/WB must not advance
- dmem_addr  out  32  word-aligned address {mem_addr[31:2],2'b00}
- dmem_rmask  out  4  byte read mask; nonzero only in the request cycle
- dmem_wmask  out  4  byte write mask; nonzero only in the request cycle
- dmem_wdata  out  32  store data shifted to byte lanes
- dmem_rdata  in  32  read data; valid when dmem_resp=1
- dmem_resp  in  1  single-cycle response strobe
- mem_wb_reg_next  out  mem_wb_stage_reg_t  next MEM/WB contents
- mem_stall  out  1  holds IF/ID/EX/MEM registers while the access is outstanding or unconsumed

Behaviour:
- Memory op: ex_mem_reg.valid && (|mem_rmask || |mem_wmask).
- FSM states: IDLE, WAIT, HOLD.
  - IDLE: on a memory op whose order differs from last_done_order, drive the dmem masks/addr/wdata for one cycle, latch the order, and go to WAIT. mem_stall=1 in this cycle.
  - WAIT: masks=0 and mem_stall=1.
    - dmem_resp && !stall: emit the result in mem_wb_reg_next this cycle, set last_done_order, go to IDLE. mem_stall=0 in the same cycle, so the pipeline advances on the next edge.
    - dmem_resp && stall: capture rdata into resp_buf and go to HOLD.
  - HOLD: mem_stall=1, masks=0, and mem_wb_reg_next is built from resp_buf. When !stall, deassert mem_stall, set last_done_order, and go to IDLE.
- A memory op whose order equals last_done_order (held by an external stall) is never reissued.
- Load data:
  - Shift by 8*mem_addr[1:0].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
  - rd_data = extended value.
- Store: dmem_wdata = rs2_data << 8*mem_addr[1:0]; regf_we is forced to 0 in the output.
- Non-memory op:
  - rd_data = aluout; mem_stall=0; the FSM stays in IDLE.
  - mem_wb_reg_next copies the pass-through fields and valid.
- Invalid input: mem_wb_reg_next = '0 and the dmem masks are 0.
- Masks are truncated to 4 bits (bits beyond lane 3 are dropped). No misalignment trap.
- While in WAIT or HOLD: mem_wb_reg_next.valid = 0, except in the completion cycle.
- Reset (asynchronous, any state, including mid-WAIT):
  - State → IDLE; last_done_order → all-ones sentinel; resp_buf → 0.
  - All outputs are 0 while rst=1.
  - Any late dmem_resp arriving after reset in IDLE is ignored.
- mem_wb_reg_next also carries rmask/wmask/addr/rdata/wdata for RVFI. The shifted masks and word address are kept.

Decomposition:
- rv32i_types (shared package) gains:
  - mem_fsm_state_t enum {MEM_IDLE, MEM_WAIT, MEM_HOLD}.
  - load funct3 constants (load_f3_lb/lh/lw/lbu/lhu).
  - store funct3 constants.
- One natural sub-module: load_align (combinational: rdata, addr[1:0], funct3 → rd_data). It is reused by any later cache-bypass path.

Test Plan:
- lw x5, addr 0x1000_0008, dmem_resp after 3 cycles with rdata 0xDEADBEEF:
  - dmem_rmask=4'b1111 for exactly one cycle; mem_stall high for 4 cycles.
  - rd_data=0xDEADBEEF, rd=5, valid=1 on the resp cycle.
- lb addr 0x...03, rdata 0x80FF_FFFF → rd_data=0xFFFFFF80; same access as lbu → 0x00000080.
- sh rs2=0x0000_1234, addr 0x...02:
  - dmem_wmask=4'b1100, dmem_wdata=0x1234_0000.
  - Output regf_we=0 and valid=1 after resp.
- stall=1 during dmem_resp with rdata 0x0000_00AA (lbu):
  - FSM enters HOLD; no second request while stall is held 5 cycles.
  - On stall release, rd_data=0xAA emitted once; mem_stall drops the same cycle.
- Back-to-back add then lw with a 1-cycle resp:
  - add passes with mem_stall=0.
  - lw issues one request; no duplicate is issued when its order persists during the stall.
- rst asserted in WAIT, then a stray dmem_resp:
  - Outputs go to 0 immediately; FSM returns to IDLE.
  - The stray response produces no valid output.
